// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS control path.
//   state_t    : FSM state encoding for mc_maindec
//   ctrl_t     : bundle of every control output driven by mc_maindec
//   ALU_*      : ALU operation classes sent to the ALU decoder
//   OP_* / F_* : instruction opcode and R-type funct values
//   imm_aluop  : ALU class for an immediate-form opcode
//   mem_size   : {half, b, lbu} load/store size select for an opcode
//   is_mdu_fn  : funct is one of mult/multu/div/divu
package mc_ctrl_pkg;

  typedef enum logic [4:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWR, S_MEMWB,
    S_RTEX, S_RTWB, S_IMMEX, S_IMMWB, S_BREX, S_JEX, S_JALEX,
    S_JREX, S_MDEX, S_MDWAIT, S_EXC
  } state_t;

  typedef struct packed {
    logic       mem_req;
    logic       irwrite;
    logic       pcwrite;
    logic       branch;
    logic       ne;
    logic       iord;
    logic       memwrite;
    logic       regwrite;
    logic       regdst;
    logic       memtoreg;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [3:0] aluop;
    logic       half;
    logic       b;
    logic       lbu;
    logic       link;
    logic       jr;
    logic       mdu_start;
    logic       mdu_busy;
    logic       illegal;
  } ctrl_t;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [3:0] ALU_BLEZ  = 4'b0010;
  localparam logic [3:0] ALU_OR    = 4'b0011;
  localparam logic [3:0] ALU_LUI   = 4'b0100;
  localparam logic [3:0] ALU_XOR   = 4'b0101;
  localparam logic [3:0] ALU_SLT   = 4'b0110;
  localparam logic [3:0] ALU_AND   = 4'b0111;
  localparam logic [3:0] ALU_SLTU  = 4'b1000;
  localparam logic [3:0] ALU_FUNCT = 4'b1111;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_BLEZ  = 6'b000110;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_LH    = 6'b100001;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_LBU   = 6'b100100;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] F_JR    = 6'b001000;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  function automatic logic [3:0] imm_aluop(input logic [5:0] op);
    logic [3:0] r;
    r = ALU_ADD;
    case (op)
      OP_ORI:   r = ALU_OR;
      OP_ANDI:  r = ALU_AND;
      OP_XORI:  r = ALU_XOR;
      OP_LUI:   r = ALU_LUI;
      OP_SLTI:  r = ALU_SLT;
      OP_SLTIU: r = ALU_SLTU;
      default:  r = ALU_ADD;
    endcase
    return r;
  endfunction

  // {half, b, lbu}
  function automatic logic [2:0] mem_size(input logic [5:0] op);
    logic [2:0] r;
    r = 3'b000;
    case (op)
      OP_LH:   r = 3'b100;
      OP_LB:   r = 3'b010;
      OP_LBU:  r = 3'b011;
      default: r = 3'b000;
    endcase
    return r;
  endfunction

  function automatic logic is_mdu_fn(input logic [5:0] funct);
    return (funct == F_MULT) || (funct == F_MULTU) ||
           (funct == F_DIV)  || (funct == F_DIVU);
  endfunction

endpackage

// File: rtl/mc_wait_cnt.sv
// Loadable down-counter with zero flag, used to time the mult/div wait.
//   clk, reset_n : clock, asynchronous active-low reset (count clears to 0)
//   load         : load load_val (has priority over dec)
//   load_val     : value to load
//   dec          : decrement by one; holds at zero
//   zero         : count is zero
module mc_wait_cnt #(
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign zero = (cnt_q == '0);

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && !zero) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mc_maindec.sv
// Multicycle MIPS main decoder: Moore FSM sequencing fetch, decode,
// execute, memory and writeback, with a memory ready handshake, a counted
// wait for the mult/div unit and an exception state for illegal opcodes.
//   clk, reset_n      : clock, asynchronous active-low reset
//   op, funct         : IR[31:26], IR[5:0]
//   mem_ready         : memory completed the current request this cycle
//   mem_req..illegal  : datapath control (see ctrl_t in mc_ctrl_pkg)
module mc_maindec
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned MDU_LATENCY = 32,
  parameter int unsigned CNT_W       = $clog2(MDU_LATENCY + 1),
  parameter bit          EN_MDU      = 1'b1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       irwrite,
  output logic       pcwrite,
  output logic       branch,
  output logic       ne,
  output logic       iord,
  output logic       memwrite,
  output logic       regwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [3:0] aluop,
  output logic       half,
  output logic       b,
  output logic       lbu,
  output logic       link,
  output logic       jr,
  output logic       mdu_start,
  output logic       mdu_busy,
  output logic       illegal
);

  state_t state_q, state_d;
  ctrl_t  ctrl, ctrl_o;
  logic   cnt_load, cnt_dec, cnt_zero;

  function automatic state_t decode_next(input logic [5:0] o, input logic [5:0] f);
    state_t s;
    s = S_EXC;
    case (o)
      OP_LW, OP_LH, OP_LB, OP_LBU, OP_SW: s = S_MEMADR;
      OP_RTYPE: begin
        if (f == F_JR) begin
          s = S_JREX;
        end else if (is_mdu_fn(f)) begin
          s = EN_MDU ? S_MDEX : S_EXC;
        end else if ((f == F_MFHI) || (f == F_MFLO)) begin
          s = EN_MDU ? S_RTEX : S_EXC;
        end else begin
          s = S_RTEX;
        end
      end
      OP_BEQ, OP_BNE, OP_BLEZ: s = S_BREX;
      OP_ADDI, OP_ORI, OP_ANDI, OP_XORI,
      OP_LUI, OP_SLTI, OP_SLTIU: s = S_IMMEX;
      OP_J:    s = S_JEX;
      OP_JAL:  s = S_JALEX;
      default: s = S_EXC;
    endcase
    return s;
  endfunction

  // MDEX loads LATENCY-1 so MDWAIT, which exits on zero, lasts LATENCY cycles.
  assign cnt_load = (state_q == S_MDEX);
  assign cnt_dec  = (state_q == S_MDWAIT);

  mc_wait_cnt #(
    .CNT_W(CNT_W)
  ) u_wait_cnt (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (cnt_load),
    .load_val (CNT_W'(MDU_LATENCY - 1)),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: state_d = decode_next(op, funct);
      S_MEMADR: state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWR:  if (mem_ready) state_d = S_FETCH;
      S_RTEX:   state_d = S_RTWB;
      S_IMMEX:  state_d = S_IMMWB;
      S_MDEX:   state_d = S_MDWAIT;
      S_MDWAIT: if (cnt_zero) state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    ctrl = '0;
    case (state_q)
      S_FETCH: begin
        ctrl.mem_req = 1'b1;
        ctrl.alusrcb = 2'b01;
        ctrl.aluop   = ALU_ADD;
        ctrl.irwrite = mem_ready;
        ctrl.pcwrite = mem_ready;
      end
      S_DECODE: begin
        ctrl.alusrcb = 2'b11;
        ctrl.aluop   = ALU_ADD;
      end
      S_MEMADR: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = 2'b10;
        ctrl.aluop   = ALU_ADD;
      end
      S_MEMRD: begin
        ctrl.mem_req = 1'b1;
        ctrl.iord    = 1'b1;
        {ctrl.half, ctrl.b, ctrl.lbu} = mem_size(op);
      end
      S_MEMWR: begin
        ctrl.mem_req  = 1'b1;
        ctrl.iord     = 1'b1;
        ctrl.memwrite = 1'b1;
        {ctrl.half, ctrl.b, ctrl.lbu} = mem_size(op);
      end
      S_MEMWB: begin
        ctrl.regwrite = 1'b1;
        ctrl.memtoreg = 1'b1;
        {ctrl.half, ctrl.b, ctrl.lbu} = mem_size(op);
      end
      S_RTEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.aluop   = ALU_FUNCT;
      end
      S_RTWB: begin
        ctrl.regwrite = 1'b1;
        ctrl.regdst   = 1'b1;
      end
      S_IMMEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = 2'b10;
        ctrl.aluop   = imm_aluop(op);
      end
      S_IMMWB: begin
        ctrl.regwrite = 1'b1;
      end
      S_BREX: begin
        ctrl.alusrca = 1'b1;
        ctrl.branch  = 1'b1;
        ctrl.pcsrc   = 2'b01;
        ctrl.aluop   = (op == OP_BLEZ) ? ALU_BLEZ : ALU_SUB;
        ctrl.ne      = (op == OP_BNE);
      end
      S_JEX: begin
        ctrl.pcwrite = 1'b1;
        ctrl.pcsrc   = 2'b10;
      end
      S_JALEX: begin
        ctrl.pcwrite  = 1'b1;
        ctrl.pcsrc    = 2'b10;
        ctrl.regwrite = 1'b1;
        ctrl.link     = 1'b1;
      end
      S_JREX: begin
        ctrl.pcwrite = 1'b1;
        ctrl.jr      = 1'b1;
      end
      S_MDEX: begin
        ctrl.mdu_start = 1'b1;
      end
      S_MDWAIT: begin
        ctrl.mdu_busy = 1'b1;
      end
      S_EXC: begin
        ctrl.illegal = 1'b1;
        ctrl.pcwrite = 1'b1;
        ctrl.pcsrc   = 2'b11;
      end
      default: ctrl = '0;
    endcase
  end

  // The reset state is FETCH, which would otherwise request memory; gating
  // with reset_n keeps every output low for as long as reset is held.
  assign ctrl_o = reset_n ? ctrl : '0;

  assign mem_req   = ctrl_o.mem_req;
  assign irwrite   = ctrl_o.irwrite;
  assign pcwrite   = ctrl_o.pcwrite;
  assign branch    = ctrl_o.branch;
  assign ne        = ctrl_o.ne;
  assign iord      = ctrl_o.iord;
  assign memwrite  = ctrl_o.memwrite;
  assign regwrite  = ctrl_o.regwrite;
  assign regdst    = ctrl_o.regdst;
  assign memtoreg  = ctrl_o.memtoreg;
  assign alusrca   = ctrl_o.alusrca;
  assign alusrcb   = ctrl_o.alusrcb;
  assign pcsrc     = ctrl_o.pcsrc;
  assign aluop     = ctrl_o.aluop;
  assign half      = ctrl_o.half;
  assign b         = ctrl_o.b;
  assign lbu       = ctrl_o.lbu;
  assign link      = ctrl_o.link;
  assign jr        = ctrl_o.jr;
  assign mdu_start = ctrl_o.mdu_start;
  assign mdu_busy  = ctrl_o.mdu_busy;
  assign illegal   = ctrl_o.illegal;

endmodule

// File: tb/tb_mc_maindec.sv
// Bench for mc_maindec: random instruction stream with random memory wait
// states; each instruction's expected control summary is computed from the
// instruction class and queued, and a monitor summarises the observed
// outputs per instruction and compares. Small extra instances cover
// EN_MDU=0 and MDU_LATENCY=1.
module tb_mc_maindec;

  localparam int LAT = 4;

  typedef struct packed {
    logic [3:0] irw, pcw, rw, mwr, m2r, st, ill, br, ne, lnk, jr;
    logic [7:0] busy;
    logic       rw_last, rd_w;
    logic [1:0] dec_b;
    logic [3:0] dec_alu, ex_alu;
    logic       ex_a;
    logic [1:0] ex_b, ex_pc;
    logic [2:0] size;
  } sig_t;

  typedef struct {
    logic [5:0] op;
    int         cyc;
    sig_t       sig;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n, mem_ready;
  logic [5:0] op, funct;
  logic mem_req, irwrite, pcwrite, branch, ne, iord, memwrite, regwrite, regdst, memtoreg, alusrca;
  logic [1:0] alusrcb, pcsrc;
  logic [3:0] aluop;
  logic half, b, lbu, link, jr, mdu_start, mdu_busy, illegal;

  logic rst2_n, mem_ready2;
  logic [5:0] op2, funct2;
  logic n_mem_req, n_irwrite, n_pcwrite, n_branch, n_ne, n_iord, n_memwrite, n_regwrite, n_regdst, n_memtoreg, n_alusrca;
  logic [1:0] n_alusrcb, n_pcsrc;
  logic [3:0] n_aluop;
  logic n_half, n_b, n_lbu, n_link, n_jr, n_mdu_start, n_mdu_busy, n_illegal;
  logic l_mem_req, l_irwrite, l_pcwrite, l_branch, l_ne, l_iord, l_memwrite, l_regwrite, l_regdst, l_memtoreg, l_alusrca;
  logic [1:0] l_alusrcb, l_pcsrc;
  logic [3:0] l_aluop;
  logic l_half, l_b, l_lbu, l_link, l_jr, l_mdu_start, l_mdu_busy, l_illegal;

  int total = 0;
  int bad = 0;
  bit mon_en = 1'b0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  mc_maindec #(.MDU_LATENCY(LAT), .EN_MDU(1'b1)) dut (
    .clk(clk), .reset_n(reset_n), .op(op), .funct(funct), .mem_ready(mem_ready),
    .mem_req(mem_req), .irwrite(irwrite), .pcwrite(pcwrite), .branch(branch), .ne(ne),
    .iord(iord), .memwrite(memwrite), .regwrite(regwrite), .regdst(regdst), .memtoreg(memtoreg),
    .alusrca(alusrca), .alusrcb(alusrcb), .pcsrc(pcsrc), .aluop(aluop), .half(half), .b(b),
    .lbu(lbu), .link(link), .jr(jr), .mdu_start(mdu_start), .mdu_busy(mdu_busy), .illegal(illegal));

  mc_maindec #(.MDU_LATENCY(LAT), .EN_MDU(1'b0)) dut_nomdu (
    .clk(clk), .reset_n(rst2_n), .op(op2), .funct(funct2), .mem_ready(mem_ready2),
    .mem_req(n_mem_req), .irwrite(n_irwrite), .pcwrite(n_pcwrite), .branch(n_branch), .ne(n_ne),
    .iord(n_iord), .memwrite(n_memwrite), .regwrite(n_regwrite), .regdst(n_regdst), .memtoreg(n_memtoreg),
    .alusrca(n_alusrca), .alusrcb(n_alusrcb), .pcsrc(n_pcsrc), .aluop(n_aluop), .half(n_half), .b(n_b),
    .lbu(n_lbu), .link(n_link), .jr(n_jr), .mdu_start(n_mdu_start), .mdu_busy(n_mdu_busy), .illegal(n_illegal));

  mc_maindec #(.MDU_LATENCY(1), .EN_MDU(1'b1)) dut_lat1 (
    .clk(clk), .reset_n(rst2_n), .op(op2), .funct(funct2), .mem_ready(mem_ready2),
    .mem_req(l_mem_req), .irwrite(l_irwrite), .pcwrite(l_pcwrite), .branch(l_branch), .ne(l_ne),
    .iord(l_iord), .memwrite(l_memwrite), .regwrite(l_regwrite), .regdst(l_regdst), .memtoreg(l_memtoreg),
    .alusrca(l_alusrca), .alusrcb(l_alusrcb), .pcsrc(l_pcsrc), .aluop(l_aluop), .half(l_half), .b(l_b),
    .lbu(l_lbu), .link(l_link), .jr(l_jr), .mdu_start(l_mdu_start), .mdu_busy(l_mdu_busy), .illegal(l_illegal));

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [26:0] all_outs();
    return {mem_req, irwrite, pcwrite, branch, ne, iord, memwrite, regwrite, regdst, memtoreg,
            alusrca, alusrcb, pcsrc, aluop, half, b, lbu, link, jr, mdu_start, mdu_busy, illegal};
  endfunction

  function automatic bit is_mem(input logic [5:0] o);
    return (o == 6'b100011) || (o == 6'b100001) || (o == 6'b100000) ||
           (o == 6'b100100) || (o == 6'b101011);
  endfunction

  // Expected per-instruction summary from the instruction's class.
  // fw/mw = cycles mem_ready is held low in fetch / data access.
  function automatic exp_t model(input logic [5:0] o, input logic [5:0] f, input int fw, input int mw);
    exp_t e;
    sig_t s;
    int fe;
    bit exc, mdu;
    s = '0;
    exc = 1'b0;
    fe = fw + 1;
    mdu = (f == 6'b011000) || (f == 6'b011001) || (f == 6'b011010) || (f == 6'b011011);
    s.irw = 4'd1; s.pcw = 4'd1; s.dec_b = 2'b11; s.dec_alu = 4'b0000;
    e.cyc = 0;
    case (o)
      6'b100011, 6'b100001, 6'b100000, 6'b100100: begin
        e.cyc = fe + mw + 4;
        s.rw = 4'd1; s.m2r = 4'd1; s.rw_last = 1'b1;
        s.ex_a = 1'b1; s.ex_b = 2'b10;
        s.size = (o == 6'b100001) ? 3'b100 : (o == 6'b100000) ? 3'b010 :
                 (o == 6'b100100) ? 3'b011 : 3'b000;
      end
      6'b101011: begin
        e.cyc = fe + mw + 3;
        s.mwr = 4'(mw + 1);
        s.ex_a = 1'b1; s.ex_b = 2'b10;
      end
      6'b000000: begin
        if (f == 6'b001000) begin
          e.cyc = fe + 2; s.pcw = 4'd2; s.jr = 4'd1;
        end else if (mdu) begin
          e.cyc = fe + 2 + LAT; s.st = 4'd1; s.busy = 8'(LAT);
        end else begin
          e.cyc = fe + 3;
          s.ex_alu = 4'b1111; s.ex_a = 1'b1;
          s.rw = 4'd1; s.rd_w = 1'b1; s.rw_last = 1'b1;
        end
      end
      6'b000100, 6'b000101, 6'b000110: begin
        e.cyc = fe + 2;
        s.br = 4'd1; s.ne = (o == 6'b000101) ? 4'd1 : 4'd0;
        s.ex_alu = (o == 6'b000110) ? 4'b0010 : 4'b0001;
        s.ex_a = 1'b1; s.ex_pc = 2'b01;
      end
      6'b001000, 6'b001101, 6'b001100, 6'b001110, 6'b001111, 6'b001010, 6'b001011: begin
        e.cyc = fe + 3;
        case (o)
          6'b001101: s.ex_alu = 4'b0011;
          6'b001100: s.ex_alu = 4'b0111;
          6'b001110: s.ex_alu = 4'b0101;
          6'b001111: s.ex_alu = 4'b0100;
          6'b001010: s.ex_alu = 4'b0110;
          6'b001011: s.ex_alu = 4'b1000;
          default:   s.ex_alu = 4'b0000;
        endcase
        s.ex_a = 1'b1; s.ex_b = 2'b10;
        s.rw = 4'd1; s.rw_last = 1'b1;
      end
      6'b000010: begin
        e.cyc = fe + 2; s.pcw = 4'd2; s.ex_pc = 2'b10;
      end
      6'b000011: begin
        e.cyc = fe + 2; s.pcw = 4'd2; s.ex_pc = 2'b10;
        s.rw = 4'd1; s.lnk = 4'd1; s.rw_last = 1'b1;
      end
      default: exc = 1'b1;
    endcase
    if (exc) begin
      e.cyc = fe + 2; s.pcw = 4'd2; s.ill = 4'd1; s.ex_pc = 2'b11;
    end
    e.op = o;
    e.sig = s;
    return e;
  endfunction

  task automatic wait_fetch();
    for (int k = 0; k < 300; k++) begin
      if (mem_req && !iord) return;
      @(posedge clk); #1;
    end
    chk("wait_fetch_timeout", 128'd0, 128'd1);
  endtask

  task automatic wait_data();
    for (int k = 0; k < 300; k++) begin
      if (mem_req && iord) return;
      @(posedge clk); #1;
    end
    chk("wait_data_timeout", 128'd0, 128'd1);
  endtask

  task automatic issue(input logic [5:0] o, input logic [5:0] f, input int fw, input int mw);
    exp_q.push_back(model(o, f, fw, mw));
    wait_fetch();
    op = o; funct = f; mem_ready = 1'b0;
    repeat (fw) begin @(posedge clk); #1; end
    mem_ready = 1'b1;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    if (is_mem(o)) begin
      wait_data();
      repeat (mw) begin @(posedge clk); #1; end
      mem_ready = 1'b1;
      @(posedge clk); #1;
      mem_ready = 1'b0;
    end
  endtask

  // Monitor: an instruction begins at a fetch cycle that follows a non-fetch
  // cycle; the previous instruction's summary is compared at that point.
  sig_t acc;
  int acc_cyc = 0;
  int since = 99;
  bit open_seg = 1'b0;
  bit prev_fetch = 1'b0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (mem_req && !iord && !prev_fetch) begin
        if (open_seg) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_instr", 128'd1, 128'd0);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk($sformatf("cycles op=%b", e.op), 128'(acc_cyc), 128'(e.cyc));
            chk($sformatf("sig op=%b", e.op), 128'(acc), 128'(e.sig));
          end
        end
        acc = '0; acc_cyc = 0; since = 99; open_seg = 1'b1;
      end
      prev_fetch = mem_req && !iord;
      if (open_seg) begin
        acc_cyc++;
        if (irwrite) since = 0;
        else if (since < 99) since++;
        acc.irw  = acc.irw + 4'(irwrite);
        acc.pcw  = acc.pcw + 4'(pcwrite);
        acc.rw   = acc.rw + 4'(regwrite);
        acc.mwr  = acc.mwr + 4'(memwrite);
        acc.m2r  = acc.m2r + 4'(memtoreg);
        acc.st   = acc.st + 4'(mdu_start);
        acc.ill  = acc.ill + 4'(illegal);
        acc.br   = acc.br + 4'(branch);
        acc.ne   = acc.ne + 4'(ne);
        acc.lnk  = acc.lnk + 4'(link);
        acc.jr   = acc.jr + 4'(jr);
        acc.busy = acc.busy + 8'(mdu_busy);
        acc.rw_last = regwrite;
        if (regwrite) acc.rd_w = acc.rd_w | regdst;
        acc.size = acc.size | {half, b, lbu};
        if (since == 1) begin
          acc.dec_b = alusrcb; acc.dec_alu = aluop;
        end
        if (since == 2) begin
          acc.ex_alu = aluop; acc.ex_a = alusrca; acc.ex_b = alusrcb; acc.ex_pc = pcsrc;
        end
      end
    end
  end

  localparam int NLEG = 18;
  logic [5:0] legal_ops [NLEG] = '{6'b100011, 6'b100001, 6'b100000, 6'b100100, 6'b101011,
    6'b000000, 6'b000000, 6'b000000, 6'b000100, 6'b000101, 6'b000110, 6'b001000, 6'b001101,
    6'b001100, 6'b001110, 6'b001111, 6'b000010, 6'b000011};
  logic [5:0] rfuncts [10] = '{6'b100000, 6'b100010, 6'b001000, 6'b011000, 6'b011001,
    6'b011010, 6'b011011, 6'b010000, 6'b010010, 6'b101010};
  logic [5:0] imm_extra [2] = '{6'b001010, 6'b001011};

  initial begin
    int n_ill, n_act, l_st, l_busy, l_rw;
    logic [1:0] n_pc;
    logic [5:0] ro, rf;
    reset_n = 1'b0; rst2_n = 1'b0; mem_ready = 1'b0; mem_ready2 = 1'b1;
    op = '0; funct = '0; op2 = '0; funct2 = '0;

    #3;
    chk("reset_outputs_zero", 128'(all_outs()), 128'd0);
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b1;

    // lw aborted by reset while waiting in the data read
    @(posedge clk); #1;
    op = 6'b100011; funct = '0; mem_ready = 1'b1;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    wait_data();
    repeat (2) begin @(posedge clk); #1; end
    chk("memrd_holding", 128'({mem_req, iord, memwrite}), 128'(3'b110));
    reset_n = 1'b0;
    #1;
    chk("reset_mid_memrd", 128'(all_outs()), 128'd0);
    @(negedge clk);
    chk("reset_held", 128'(all_outs()), 128'd0);
    #2 reset_n = 1'b1;
    @(negedge clk);
    chk("post_reset_fetch", 128'({mem_req, iord, alusrcb, irwrite, regwrite, memwrite}),
        128'({1'b1, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0}));

    @(posedge clk); #1;
    mon_en = 1'b1;
    issue(6'b100011, 6'b000000, 3, 2);   // lw with fetch and read waits
    issue(6'b000000, 6'b100000, 0, 0);   // add
    issue(6'b000101, 6'b000000, 0, 0);   // bne
    issue(6'b000000, 6'b011000, 0, 0);   // mult
    issue(6'b111111, 6'b000000, 0, 0);   // illegal
    issue(6'b101011, 6'b000000, 1, 3);   // sw
    issue(6'b001010, 6'b000000, 0, 0);   // slti
    issue(6'b001011, 6'b000000, 2, 0);   // sltiu
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 9) < 7) ro = legal_ops[$urandom_range(0, NLEG - 1)];
      else if ($urandom_range(0, 1) == 0) ro = imm_extra[$urandom_range(0, 1)];
      else ro = 6'($urandom);
      rf = ($urandom_range(0, 4) == 0) ? 6'($urandom) : rfuncts[$urandom_range(0, 9)];
      issue(ro, rf, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end
    wait_fetch();
    repeat (2) @(negedge clk);
    for (int k = 0; k < 50 && exp_q.size() != 0; k++) @(negedge clk);
    chk("scoreboard_drained", 128'(exp_q.size()), 128'd0);
    mon_en = 1'b0;

    // mult on EN_MDU=0 (trap) and on MDU_LATENCY=1 (single wait cycle)
    op2 = 6'b000000; funct2 = 6'b011000;
    @(posedge clk); #1 rst2_n = 1'b1;
    n_ill = 0; n_act = 0; l_st = 0; l_busy = 0; n_pc = 2'b00;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_ill += int'(n_illegal);
      n_act += int'(n_mdu_start) + int'(n_mdu_busy);
      l_st += int'(l_mdu_start);
      l_busy += int'(l_mdu_busy);
      if (k == 2) n_pc = n_pcsrc;
    end
    chk("nomdu_mult_illegal", 128'(n_ill), 128'd1);
    chk("nomdu_mult_no_mdu", 128'(n_act), 128'd0);
    chk("nomdu_mult_pcsrc", 128'(n_pc), 128'(2'b11));
    chk("lat1_start", 128'(l_st), 128'd1);
    chk("lat1_busy", 128'(l_busy), 128'd1);
    @(negedge clk);
    chk("lat1_back_to_fetch", 128'({l_mem_req, l_iord, l_irwrite}), 128'(3'b101));

    // mfhi: trap without the MDU, ordinary R-type with it
    rst2_n = 1'b0; funct2 = 6'b010000;
    @(posedge clk); #1 rst2_n = 1'b1;
    n_ill = 0; l_rw = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_ill += int'(n_illegal);
      l_rw += int'(l_regwrite && l_regdst);
    end
    chk("nomdu_mfhi_illegal", 128'(n_ill), 128'd1);
    chk("lat1_mfhi_rtype", 128'(l_rw), 128'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
